// File: rtl/load_buffer.sv
// In-order load buffer between the address unit and the single-port data memory.
// Optional LB_MISALIGN_CHECK_EN: misaligned loads complete with lb_wr_exception=1 instead of reading memory.
module load_buffer #(
    parameter int LB_DEPTH = 4,
    parameter int TAG_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic [1:0]       ld_size,
    input  logic             ld_unsigned,
    input  logic [TAG_W-1:0] ld_tag,
    output logic             lb_full,
    input  logic             lb_exec_stall,
    input  logic             flush,
    output logic             lb_read_mem,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata,
    input  logic             lb_wr_enable,
    output logic             lb_wr_valid,
    output logic [TAG_W-1:0] lb_wr_tag,
`ifdef LB_MISALIGN_CHECK_EN
    output logic             lb_wr_exception,
`endif
    output logic [31:0]      lb_wr_value
);

    localparam int PTR_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      r_addr     [LB_DEPTH];
    logic [1:0]       r_size     [LB_DEPTH];
    logic             r_unsigned [LB_DEPTH];
    logic [TAG_W-1:0] r_tag      [LB_DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_wr_valid;
    logic [TAG_W-1:0] r_wr_tag;
    logic [31:0]      r_wr_value;

    logic             w_nonempty;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head_addr;
    logic [1:0]       w_head_size;
    logic             w_head_unsigned;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_fmt_value;

    assign lb_full    = (r_count == CNT_W'(LB_DEPTH));
    assign w_nonempty = (r_count != '0);
    // The pop itself only depends on the stall and flush; the port may stay free for a faulting load.
    assign w_pop      = w_nonempty & ~lb_exec_stall & ~flush;
    assign w_push     = ld_valid & ~lb_full & ~flush;

    assign w_head_addr     = r_addr[r_head];
    assign w_head_size     = r_size[r_head];
    assign w_head_unsigned = r_unsigned[r_head];
    assign mem_addr        = {w_head_addr[31:2], 2'b00};

`ifdef LB_MISALIGN_CHECK_EN
    logic r_wr_exception;
    logic w_misaligned;

    assign w_misaligned = ((w_head_size == 2'd1) & w_head_addr[0]) |
                          (w_head_size[1] & (w_head_addr[1:0] != 2'b00));
    assign lb_read_mem  = w_pop & ~w_misaligned;
    assign lb_wr_exception = r_wr_exception;
`else
    assign lb_read_mem  = w_pop;
`endif

    // Entry storage: each slot is written only when the tail points at it.
    generate
        for (genvar gi = 0; gi < LB_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_addr[gi]     <= '0;
                    r_size[gi]     <= '0;
                    r_unsigned[gi] <= 1'b0;
                    r_tag[gi]      <= '0;
                end else if (w_push && (r_tail == PTR_W'(gi))) begin
                    r_addr[gi]     <= ld_addr;
                    r_size[gi]     <= ld_size;
                    r_unsigned[gi] <= ld_unsigned;
                    r_tag[gi]      <= ld_tag;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_comb begin
        w_byte = mem_rdata[8*w_head_addr[1:0] +: 8];
        w_half = w_head_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (w_head_size)
            2'd0:    w_fmt_value = w_head_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_fmt_value = w_head_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_fmt_value = mem_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_valid <= 1'b0;
            r_wr_tag   <= '0;
            r_wr_value <= '0;
        end else if (flush) begin
            r_wr_valid <= 1'b0;
        end else if (w_pop) begin
            r_wr_valid <= 1'b1;
            r_wr_tag   <= r_tag[r_head];
`ifdef LB_MISALIGN_CHECK_EN
            r_wr_value <= w_misaligned ? 32'd0 : w_fmt_value;
`else
            r_wr_value <= w_fmt_value;
`endif
        end else if (lb_wr_enable) begin
            r_wr_valid <= 1'b0;
        end
    end

`ifdef LB_MISALIGN_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset)      r_wr_exception <= 1'b0;
        else if (flush) r_wr_exception <= r_wr_exception;
        else if (w_pop) r_wr_exception <= w_misaligned;
    end
`endif

    assign lb_wr_valid = r_wr_valid;
    assign lb_wr_tag   = r_wr_tag;
    assign lb_wr_value = r_wr_value;

endmodule
